// File: rtl/pwm_cfg_loader_if.sv
// Byte-stream and configuration-strobe bundle between a frame source and pwm_cfg_loader.
// The bundle also carries the strobe side that feeds the PWM generator.
interface pwm_cfg_loader_if #(
    parameter int DATA_W = 12
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_sel;
    logic              cfg_wr_en;
    logic              busy;
    logic [1:0]        err_code;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  cfg_data,
        input  cfg_sel,
        input  cfg_wr_en,
        input  busy,
        input  err_code
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output cfg_data,
        output cfg_sel,
        output cfg_wr_en,
        output busy,
        output err_code
    );
endinterface

// File: rtl/pwm_cfg_loader.sv
// Byte-serial loader: turns 3-byte frames (command, data-high, data-low) into
// range-checked single-cycle write strobes for the PWM generator.
module pwm_cfg_loader #(
    parameter int          DATA_W   = 12,
    parameter logic [3:0]  MAGIC    = 4'hA,
    parameter int unsigned DUTY_MAX = 100,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    pwm_cfg_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_HI = 2'd1,
        GET_LO = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MAGIC   = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [15:0]      DUTY_LIM = 16'(DUTY_MAX);

    // Payload must fit the data word; duty writes are further capped at DUTY_MAX.
    function automatic logic frame_legal(input logic [15:0] value, input logic sel);
        logic range_ok;
        logic duty_ok;
        range_ok = ((value >> DATA_W) == 16'd0);
        duty_ok  = sel | (value <= DUTY_LIM);
        return range_ok & duty_ok;
    endfunction

    state_t            state_r, state_s;
    logic              sel_r, sel_s;
    logic [7:0]        hi_r, hi_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] cfg_data_r, cfg_data_s;
    logic              cfg_sel_r, cfg_sel_s;
    logic              wr_en_r, wr_en_s;
    logic [1:0]        err_r, err_s;
    logic              ready_s;
    logic              accept_s;
    logic [15:0]       value_s;

    assign ready_s  = (state_r != COMMIT);
    assign accept_s = bus.byte_valid & ready_s;
    assign value_s  = {hi_r, bus.byte_in};

    assign bus.byte_ready = ready_s;
    assign bus.busy       = (state_r != IDLE);
    assign bus.cfg_data   = cfg_data_r;
    assign bus.cfg_sel    = cfg_sel_r;
    assign bus.cfg_wr_en  = wr_en_r;
    assign bus.err_code   = err_r;

    // Next-state and next-output decode; the strobe is registered so it lands in COMMIT.
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        hi_s       = hi_r;
        cnt_s      = cnt_r;
        cfg_data_s = cfg_data_r;
        cfg_sel_s  = cfg_sel_r;
        wr_en_s    = 1'b0;
        err_s      = err_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (bus.byte_in[7:4] == MAGIC) begin
                        sel_s   = bus.byte_in[0];
                        err_s   = ERR_NONE;
                        cnt_s   = CNT_ZERO;
                        state_s = GET_HI;
                    end else begin
                        err_s = ERR_MAGIC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            GET_HI, GET_LO: begin
                if (accept_s) begin
                    cnt_s = CNT_ZERO;
                    if (state_r == GET_HI) begin
                        hi_s    = bus.byte_in;
                        state_s = GET_LO;
                    end else begin
                        state_s = COMMIT;
                        if (frame_legal(value_s, sel_r)) begin
                            wr_en_s    = 1'b1;
                            cfg_data_s = value_s[DATA_W-1:0];
                            cfg_sel_s  = sel_r;
                        end else begin
                            err_s = ERR_RANGE;
                        end
                    end
                end else if (cnt_r == CNT_LAST) begin
                    // A byte arriving on this same edge is handled above and wins.
                    cnt_s   = CNT_ZERO;
                    err_s   = ERR_TIMEOUT;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            COMMIT: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sel_r      <= 1'b0;
            hi_r       <= 8'd0;
            cnt_r      <= CNT_ZERO;
            cfg_data_r <= {DATA_W{1'b0}};
            cfg_sel_r  <= 1'b0;
            wr_en_r    <= 1'b0;
            err_r      <= ERR_NONE;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            hi_r       <= hi_s;
            cnt_r      <= cnt_s;
            cfg_data_r <= cfg_data_s;
            cfg_sel_r  <= cfg_sel_s;
            wr_en_r    <= wr_en_s;
            err_r      <= err_s;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Directed bench for pwm_cfg_loader: a frame-level reference model checked every
// cycle, plus hand-computed expectations at the points of interest.
module tb_pwm_cfg_loader;

    localparam int DATA_W   = 12;
    localparam int TIMEOUT  = 255;
    localparam int DUTY_MAX = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    pwm_cfg_loader_if #(.DATA_W(DATA_W)) ifc ();

    pwm_cfg_loader #(
        .DATA_W  (DATA_W),
        .MAGIC   (4'hA),
        .DUTY_MAX(DUTY_MAX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Reference view: how many frame bytes are held, idle count, and the visible outputs.
    typedef struct packed {
        logic [1:0]  nbytes;
        logic        commit;
        logic [8:0]  idle;
        logic [7:0]  hi;
        logic        fsel;
        logic [11:0] data;
        logic        sel;
        logic        wr;
        logic [1:0]  err;
    } model_t;

    model_t m = '0;
    logic   model_on = 1'b0;

    function automatic model_t model_next(input model_t s, input logic r,
                                          input logic v, input logic [7:0] b);
        model_t t;
        logic   acc;
        int     value;
        t = s;
        if (r) begin
            t = '0;
        end else begin
            t.wr = 1'b0;
            acc  = v && !s.commit;
            if (s.commit) begin
                t.commit = 1'b0;
            end else if (s.nbytes == 2'd0) begin
                if (acc) begin
                    if (b[7:4] == 4'hA) begin
                        t.fsel   = b[0];
                        t.err    = 2'd0;
                        t.nbytes = 2'd1;
                        t.idle   = 9'd0;
                    end else begin
                        t.err = 2'd1;
                    end
                end
            end else if (acc) begin
                t.idle = 9'd0;
                if (s.nbytes == 2'd1) begin
                    t.hi     = b;
                    t.nbytes = 2'd2;
                end else begin
                    value    = int'(s.hi) * 256 + int'(b);
                    t.nbytes = 2'd0;
                    t.commit = 1'b1;
                    if (value < (1 << DATA_W) && (s.fsel || value <= DUTY_MAX)) begin
                        t.wr   = 1'b1;
                        t.data = value[11:0];
                        t.sel  = s.fsel;
                    end else begin
                        t.err = 2'd2;
                    end
                end
            end else if (int'(s.idle) == TIMEOUT - 1) begin
                t.nbytes = 2'd0;
                t.idle   = 9'd0;
                t.err    = 2'd3;
            end else begin
                t.idle = s.idle + 9'd1;
            end
        end
        return t;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst, ifc.byte_valid, ifc.byte_in);
        if (rst) model_on <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_ready", 32'(ifc.byte_ready), 32'(!m.commit));
            chk("m_busy",  32'(ifc.busy),       32'((m.nbytes != 2'd0) || m.commit));
            chk("m_wr",    32'(ifc.cfg_wr_en),  32'(m.wr));
            chk("m_data",  32'(ifc.cfg_data),   32'(m.data));
            chk("m_sel",   32'(ifc.cfg_sel),    32'(m.sel));
            chk("m_err",   32'(ifc.err_code),   32'(m.err));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted (bounded).
    task automatic send(input logic [7:0] b, input int gap);
        logic got;
        logic done;
        done = 1'b0;
        ifc.byte_valid = 1'b0;
        repeat (gap) next_cycle();
        ifc.byte_in    = b;
        ifc.byte_valid = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            got = ifc.byte_ready;
            next_cycle();
            done = got;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_accept: byte 0x%0h not taken, got ready 0 expected 1", b);
        end
        ifc.byte_valid = 1'b0;
    endtask

    initial begin
        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy",  32'(ifc.busy),       32'd0);
        chk("rst_ready", 32'(ifc.byte_ready), 32'd1);
        chk("rst_data",  32'(ifc.cfg_data),   32'd0);
        chk("rst_wr",    32'(ifc.cfg_wr_en),  32'd0);
        chk("rst_err",   32'(ifc.err_code),   32'd0);

        // period 1000, back-to-back
        send(8'hA1, 0); send(8'h03, 0); send(8'hE8, 0);
        chk("t1_wr",    32'(ifc.cfg_wr_en),  32'd1);
        chk("t1_data",  32'(ifc.cfg_data),   32'h3E8);
        chk("t1_sel",   32'(ifc.cfg_sel),    32'd1);
        chk("t1_err",   32'(ifc.err_code),   32'd0);
        chk("t1_ready", 32'(ifc.byte_ready), 32'd0);
        next_cycle();
        chk("t1_wr_off", 32'(ifc.cfg_wr_en), 32'd0);
        chk("t1_busy",   32'(ifc.busy),      32'd0);

        // duty 50 with gaps
        send(8'hA0, 3); send(8'h00, 3); send(8'h32, 3);
        chk("t2_wr",   32'(ifc.cfg_wr_en), 32'd1);
        chk("t2_data", 32'(ifc.cfg_data),  32'h032);
        chk("t2_sel",  32'(ifc.cfg_sel),   32'd0);
        next_cycle();

        // duty 101 rejected
        send(8'hA0, 0); send(8'h00, 0); send(8'h65, 0);
        chk("t3_wr",   32'(ifc.cfg_wr_en), 32'd0);
        chk("t3_err",  32'(ifc.err_code),  32'd2);
        chk("t3_data", 32'(ifc.cfg_data),  32'h032);
        next_cycle();

        // period 4096 rejected, then bad magic
        send(8'hA1, 0); send(8'h10, 0); send(8'h00, 0);
        chk("t4_wr",  32'(ifc.cfg_wr_en), 32'd0);
        chk("t4_err", 32'(ifc.err_code),  32'd2);
        send(8'h51, 0);
        chk("t4_magic", 32'(ifc.err_code), 32'd1);
        chk("t4_busy",  32'(ifc.busy),     32'd0);

        // boundaries: duty exactly 100, period exactly 4095
        send(8'hA0, 0); send(8'h00, 0); send(8'h64, 0);
        chk("duty_max_wr",   32'(ifc.cfg_wr_en), 32'd1);
        chk("duty_max_data", 32'(ifc.cfg_data),  32'h064);
        send(8'hA3, 0); send(8'h0F, 0); send(8'hFF, 0);
        chk("per_max_wr",   32'(ifc.cfg_wr_en), 32'd1);
        chk("per_max_data", 32'(ifc.cfg_data),  32'hFFF);
        chk("per_max_sel",  32'(ifc.cfg_sel),   32'd1);

        // timeout after TIMEOUT idle cycles
        send(8'hA1, 0);
        repeat (TIMEOUT - 1) next_cycle();
        chk("t5_still_busy", 32'(ifc.busy), 32'd1);
        next_cycle();
        chk("t5_busy", 32'(ifc.busy),     32'd0);
        chk("t5_err",  32'(ifc.err_code), 32'd3);
        send(8'hA1, 0); send(8'h00, 0); send(8'h10, 0);
        chk("t5_wr",   32'(ifc.cfg_wr_en), 32'd1);
        chk("t5_data", 32'(ifc.cfg_data),  32'h010);
        chk("t5_err2", 32'(ifc.err_code),  32'd0);

        // byte arriving on the timeout edge wins
        send(8'hA1, 0); send(8'h00, TIMEOUT - 1);
        chk("race_busy", 32'(ifc.busy), 32'd1);
        send(8'h05, 0);
        chk("race_wr",   32'(ifc.cfg_wr_en), 32'd1);
        chk("race_data", 32'(ifc.cfg_data),  32'h005);

        // reset mid-frame
        send(8'hA1, 0); send(8'h03, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("t6_busy",  32'(ifc.busy),       32'd0);
        chk("t6_data",  32'(ifc.cfg_data),   32'd0);
        chk("t6_sel",   32'(ifc.cfg_sel),    32'd0);
        chk("t6_wr",    32'(ifc.cfg_wr_en),  32'd0);
        chk("t6_err",   32'(ifc.err_code),   32'd0);
        chk("t6_ready", 32'(ifc.byte_ready), 32'd1);
        send(8'hE8, 0);
        chk("t6_magic", 32'(ifc.err_code),  32'd1);
        chk("t6_nowr",  32'(ifc.cfg_wr_en), 32'd0);
        repeat (5) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
